// File: rtl/id_ex_operand_stage.sv
// Decode-to-execute issue stage: operand forwarding from MEM/WB, RAW hazard stall detection,
// and the ID/EX pipeline register with bubble insertion on stall or flush.
module id_ex_operand_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_r1_num,
    input  logic              id_r1_used,
    input  logic [4:0]        id_r2_num,
    input  logic              id_r2_used,
    input  logic [4:0]        id_wr_num,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    output logic [4:0]        rf_r1_num,
    output logic [4:0]        rf_r2_num,
    input  logic [31:0]       rf_a,
    input  logic [31:0]       rf_b,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [4:0]        mem_wr_num,
    input  logic [31:0]       mem_result,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_wr_num,
    input  logic [31:0]       wb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_b,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_wr_num,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [CNT_W-1:0]  perf_stall_cnt
);

    logic              ex_valid_reg;
    logic [31:0]       ex_a_reg;
    logic [31:0]       ex_b_reg;
    logic [31:0]       ex_imm_reg;
    logic [CTRL_W-1:0] ex_ctrl_reg;
    logic [4:0]        ex_wr_num_reg;
    logic              ex_reg_write_reg;
    logic              ex_mem_read_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic [1:0][4:0]   src_num;
    logic [1:0]        src_used;
    logic [1:0][31:0]  rf_data;
    logic [1:0][31:0]  operand;
    logic [1:0]        hazard;

    assign rf_r1_num = id_r1_num;
    assign rf_r2_num = id_r2_num;

    assign src_num  = {id_r2_num, id_r1_num};
    assign src_used = {id_r2_used, id_r1_used};
    assign rf_data  = {rf_b, rf_a};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic is_zero;
            logic needed;
            logic ex_hit;
            logic load_hit;
            logic fwd_mem;
            logic fwd_wb;

            assign is_zero  = (src_num[gi] == 5'd0);
            assign needed   = id_valid & src_used[gi] & ~is_zero;
            // EX result is not computed yet; a load in MEM has no data until WB.
            assign ex_hit   = ex_valid_reg & ex_reg_write_reg & (ex_wr_num_reg == src_num[gi]);
            assign load_hit = mem_valid & mem_reg_write & mem_mem_read & (mem_wr_num == src_num[gi]);
            assign hazard[gi] = needed & (ex_hit | load_hit);

            assign fwd_mem = mem_valid & mem_reg_write & ~mem_mem_read & (mem_wr_num == src_num[gi]);
            assign fwd_wb  = wb_valid & wb_reg_write & (wb_wr_num == src_num[gi]);
            assign operand[gi] = is_zero ? 32'd0 :
                                 fwd_mem ? mem_result :
                                 fwd_wb  ? wb_data : rf_data[gi];
        end
    endgenerate

    assign stall = (|hazard) & ~flush & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg     <= 1'b0;
            ex_a_reg         <= 32'd0;
            ex_b_reg         <= 32'd0;
            ex_imm_reg       <= 32'd0;
            ex_ctrl_reg      <= '0;
            ex_wr_num_reg    <= 5'd0;
            ex_reg_write_reg <= 1'b0;
            ex_mem_read_reg  <= 1'b0;
            stall_cnt_reg    <= '0;
        end else begin
            if (flush | stall) begin
                // Bubble: kill write enables, leave data fields holding.
                ex_valid_reg     <= 1'b0;
                ex_reg_write_reg <= 1'b0;
                ex_mem_read_reg  <= 1'b0;
            end else begin
                ex_valid_reg     <= id_valid;
                ex_a_reg         <= operand[0];
                ex_b_reg         <= operand[1];
                ex_imm_reg       <= id_imm;
                ex_ctrl_reg      <= id_ctrl;
                ex_wr_num_reg    <= id_wr_num;
                ex_reg_write_reg <= id_reg_write & id_valid;
                ex_mem_read_reg  <= id_mem_read & id_valid;
            end
            if (stall && stall_cnt_reg != {CNT_W{1'b1}})
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign ex_valid       = ex_valid_reg;
    assign ex_a           = ex_a_reg;
    assign ex_b           = ex_b_reg;
    assign ex_imm         = ex_imm_reg;
    assign ex_ctrl        = ex_ctrl_reg;
    assign ex_wr_num      = ex_wr_num_reg;
    assign ex_reg_write   = ex_reg_write_reg;
    assign ex_mem_read    = ex_mem_read_reg;
    assign perf_stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed pipeline scenarios plus randomized inputs,
// every cycle compared against a behavioural model of the issue rules.
module tb_id_ex_operand_stage;

    localparam int CTRL_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [4:0]        id_r1_num, id_r2_num, id_wr_num;
    logic              id_r1_used, id_r2_used, id_reg_write, id_mem_read;
    logic [31:0]       id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              flush;
    logic [4:0]        rf_r1_num, rf_r2_num;
    logic [31:0]       rf_a, rf_b;
    logic              mem_valid, mem_reg_write, mem_mem_read;
    logic [4:0]        mem_wr_num;
    logic [31:0]       mem_result;
    logic              wb_valid, wb_reg_write;
    logic [4:0]        wb_wr_num;
    logic [31:0]       wb_data;
    logic              stall;
    logic              ex_valid;
    logic [31:0]       ex_a, ex_b, ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_wr_num;
    logic              ex_reg_write, ex_mem_read;
    logic [CNT_W-1:0]  perf_stall_cnt;

    id_ex_operand_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_r1_num(id_r1_num), .id_r1_used(id_r1_used),
        .id_r2_num(id_r2_num), .id_r2_used(id_r2_used),
        .id_wr_num(id_wr_num), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush),
        .rf_r1_num(rf_r1_num), .rf_r2_num(rf_r2_num), .rf_a(rf_a), .rf_b(rf_b),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_wr_num(mem_wr_num), .mem_result(mem_result),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_wr_num(wb_wr_num), .wb_data(wb_data),
        .stall(stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_ctrl(ex_ctrl), .ex_wr_num(ex_wr_num), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit pipe     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model of the ID/EX contents and the stall counter.
    bit          model_known = 1'b0;
    logic        m_valid, m_rw, m_mr, m_a_chk, m_b_chk;
    logic [4:0]  m_wr;
    logic [31:0] m_a, m_b, m_imm;
    logic [7:0]  m_ctrl;
    int unsigned m_cnt;

    function automatic bit blocked(input logic used, input logic [4:0] s);
        if (!id_valid || !used || s == 5'd0) return 1'b0;
        return (m_valid && m_rw && m_wr == s) ||
               (mem_valid && mem_reg_write && mem_mem_read && mem_wr_num == s);
    endfunction

    function automatic bit exp_stall();
        return (blocked(id_r1_used, id_r1_num) || blocked(id_r2_used, id_r2_num)) && !flush && !rst;
    endfunction

    function automatic logic [31:0] source_value(input logic [4:0] s, input logic [31:0] rf);
        if (s == 5'd0) return 32'd0;
        if (mem_valid && mem_reg_write && !mem_mem_read && mem_wr_num == s) return mem_result;
        if (wb_valid && wb_reg_write && wb_wr_num == s) return wb_data;
        return rf;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_known <= 1'b1;
            m_valid <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0; m_wr <= 5'd0;
            m_a <= 32'd0; m_b <= 32'd0; m_imm <= 32'd0; m_ctrl <= 8'd0;
            m_a_chk <= 1'b1; m_b_chk <= 1'b1; m_cnt <= 0;
        end else if (model_known) begin
            if (exp_stall() && m_cnt < 32'hFFFF) m_cnt <= m_cnt + 1;
            if (flush || exp_stall()) begin
                m_valid <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0;
            end else begin
                m_valid <= id_valid;
                m_rw    <= id_valid && id_reg_write;
                m_mr    <= id_valid && id_mem_read;
                m_wr    <= id_wr_num;
                m_imm   <= id_imm;
                m_ctrl  <= id_ctrl;
                m_a     <= source_value(id_r1_num, rf_a);
                m_b     <= source_value(id_r2_num, rf_b);
                m_a_chk <= id_r1_used;
                m_b_chk <= id_r2_used;
            end
        end
    end

    always @(negedge clk) begin
        if (model_known) begin
            check("stall", stall, exp_stall());
            check("ex_valid", ex_valid, m_valid);
            check("ex_reg_write", ex_reg_write, m_rw);
            check("ex_mem_read", ex_mem_read, m_mr);
            check("perf_stall_cnt", perf_stall_cnt, m_cnt);
            check("rf_r1_num", rf_r1_num, id_r1_num);
            check("rf_r2_num", rf_r2_num, id_r2_num);
            if (m_valid) begin
                check("ex_wr_num", ex_wr_num, m_wr);
                check("ex_imm", ex_imm, m_imm);
                check("ex_ctrl", ex_ctrl, m_ctrl);
                if (m_a_chk) check("ex_a", ex_a, m_a);
                if (m_b_chk) check("ex_b", ex_b, m_b);
            end
        end
    end

    // Advance one cycle; in pipe mode the bench plays the MEM and WB stages behind ID/EX.
    task automatic step();
        logic pv, prw, pmr;
        logic [4:0] pwr;
        pv = m_valid; prw = m_rw; pmr = m_mr; pwr = m_wr;
        @(posedge clk); #1;
        if (pipe) begin
            wb_valid      = mem_valid;
            wb_reg_write  = mem_reg_write;
            wb_wr_num     = mem_wr_num;
            wb_data       = mem_mem_read ? 32'hCAFE : mem_result;
            mem_valid     = pv;
            mem_reg_write = prw;
            mem_mem_read  = pmr;
            mem_wr_num    = pwr;
            mem_result    = 32'hDEAD;
        end
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wr,
                         input logic ld, output int nst);
        bit done;
        id_valid = 1'b1; id_r1_num = r1; id_r2_num = r2; id_r1_used = 1'b1; id_r2_used = 1'b1;
        id_wr_num = wr; id_reg_write = 1'b1; id_mem_read = ld;
        id_imm = $urandom; id_ctrl = 8'($urandom);
        nst = 0;
        done = 1'b0;
        for (int i = 0; i < 4 && !done; i++) begin
            #1;
            if (stall === 1'b1) nst++;
            else done = 1'b1;
            step();
        end
        id_valid = 1'b0;
    endtask

    task automatic clear_stages();
        mem_valid = 0; mem_reg_write = 0; mem_mem_read = 0; mem_wr_num = 0; mem_result = 0;
        wb_valid = 0; wb_reg_write = 0; wb_wr_num = 0; wb_data = 0;
    endtask

    int nst;
    int unsigned cnt0;

    initial begin
        // T1: reset with a live instruction and a load hazard pending
        rst = 1; flush = 0; clear_stages();
        id_valid = 1; id_r1_num = 5; id_r1_used = 1; id_r2_num = 0; id_r2_used = 0;
        id_wr_num = 1; id_reg_write = 1; id_mem_read = 0; id_imm = 32'h1234; id_ctrl = 8'h5A;
        rf_a = 32'h99; rf_b = 32'h88;
        mem_valid = 1; mem_reg_write = 1; mem_mem_read = 1; mem_wr_num = 5;
        #1;
        check("T1 stall in reset", stall, 1'b0);
        step(); step();
        check("T1 ex_valid", ex_valid, 1'b0);
        check("T1 ex_a", ex_a, 32'd0);
        check("T1 cnt", perf_stall_cnt, 16'd0);
        rst = 0; id_valid = 0; clear_stages();
        step();

        // T2: no hazard, operands straight from the register file
        rf_a = 32'h11; rf_b = 32'h22;
        issue(5'd3, 5'd4, 5'd10, 1'b0, nst);
        check("T2 ex_a", ex_a, 32'h11);
        check("T2 ex_b", ex_b, 32'h22);
        check("T2 ex_valid", ex_valid, 1'b1);
        check("T2 stalls", nst, 0);
        step(); step();

        // T3: ALU-use
        pipe = 1'b1; clear_stages(); rf_a = 32'h0; rf_b = 32'h0;
        step(); step();
        issue(5'd1, 5'd2, 5'd5, 1'b0, nst);
        issue(5'd5, 5'd5, 5'd6, 1'b0, nst);
        check("T3 stalls", nst, 1);
        check("T3 ex_a", ex_a, 32'hDEAD);
        check("T3 ex_b", ex_b, 32'hDEAD);
        check("T3 ex_valid", ex_valid, 1'b1);
        step(); step(); step();

        // T4: load-use, two stalls then WB forwarding
        issue(5'd1, 5'd2, 5'd7, 1'b1, nst);
        cnt0 = perf_stall_cnt;
        issue(5'd7, 5'd0, 5'd8, 1'b0, nst);
        check("T4 stalls", nst, 2);
        check("T4 cnt delta", perf_stall_cnt - cnt0, 2);
        check("T4 ex_a", ex_a, 32'hCAFE);
        check("T4 ex_b", ex_b, 32'd0);
        step(); step(); step();
        pipe = 1'b0; clear_stages();

        // T5: register 0 ignores forwarding; MEM beats WB
        id_valid = 1; id_r1_num = 0; id_r1_used = 1; id_r2_num = 0; id_r2_used = 0;
        id_reg_write = 0; id_mem_read = 0; rf_a = 32'h77;
        mem_valid = 1; mem_reg_write = 1; mem_wr_num = 0; mem_result = 32'h55;
        #1;
        check("T5 r0 stall", stall, 1'b0);
        step();
        check("T5 r0 ex_a", ex_a, 32'd0);
        id_r1_num = 9; mem_wr_num = 9; mem_result = 32'h1111;
        wb_valid = 1; wb_reg_write = 1; wb_wr_num = 9; wb_data = 32'h2222;
        step();
        check("T5 priority ex_a", ex_a, 32'h1111);
        clear_stages(); id_valid = 0;
        step();

        // T6: flush beats stall, then counter saturation
        issue(5'd1, 5'd2, 5'd5, 1'b0, nst);
        id_valid = 1; id_r1_num = 5; id_r1_used = 1; id_r2_used = 0; id_reg_write = 0;
        flush = 1;
        #1;
        check("T6 flush stall", stall, 1'b0);
        cnt0 = perf_stall_cnt;
        step();
        check("T6 flush ex_valid", ex_valid, 1'b0);
        check("T6 flush cnt", perf_stall_cnt, cnt0);
        flush = 0;
        mem_valid = 1; mem_reg_write = 1; mem_mem_read = 1; mem_wr_num = 5;
        repeat ((1 << CNT_W) + 3) step();
        check("T6 saturated cnt", perf_stall_cnt, 16'hFFFF);
        check("T6 still stalling", stall, 1'b1);
        clear_stages(); id_valid = 0;
        step();

        // Randomized traffic over a small register range so matches are frequent
        repeat (1500) begin
            rst = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 9) == 0);
            id_valid = 1'($urandom); id_r1_used = 1'($urandom); id_r2_used = 1'($urandom);
            id_r1_num = 5'($urandom_range(0, 7)); id_r2_num = 5'($urandom_range(0, 7));
            id_wr_num = 5'($urandom_range(0, 7));
            id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
            id_imm = $urandom; id_ctrl = 8'($urandom);
            rf_a = $urandom; rf_b = $urandom;
            mem_valid = 1'($urandom); mem_reg_write = 1'($urandom); mem_mem_read = 1'($urandom);
            mem_wr_num = 5'($urandom_range(0, 7)); mem_result = $urandom;
            wb_valid = 1'($urandom); wb_reg_write = 1'($urandom);
            wb_wr_num = 5'($urandom_range(0, 7)); wb_data = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
